// File: rtl/ps2_pkg.sv
// Shared frame constants, receiver state encoding and parity helper
// for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = FRAME_BITS - 3;
    localparam logic START_VAL  = 1'b0;
    localparam logic STOP_VAL   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the raw PS/2 clock, rejects short glitches and emits a
// one-cycle strobe on each accepted falling edge.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    output logic fall_stb
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]       sync_q;
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            fall_stb <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], ps2_clk};
            fall_stb <= 1'b0;
            // Any sample that agrees with the current level restarts the run.
            if (sync_q[1] != filt_q) begin
                if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                    filt_q   <= sync_q[1];
                    cnt_q    <= '0;
                    fall_stb <= filt_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with a one-byte holding register,
// parity/stop/timeout checking and overrun detection.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic                 OSCCLK,
    input  logic                 RESET_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam longint unsigned TIMEOUT_CYC = 64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1000000;
    localparam int              TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int              BIT_W       = $clog2(DATA_BITS);

    logic                 clk_fall;
    logic [1:0]           data_sync;
    logic                 data_s;

    ps2_state_t           state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic [TO_W-1:0]      to_cnt;
    logic                 to_hit;

    ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk      (OSCCLK),
        .rst_n    (RESET_n),
        .ps2_clk  (ps2_clk),
        .fall_stb (clk_fall)
    );

    always_ff @(posedge OSCCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            data_sync <= 2'b11;
        end else begin
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign data_s = data_sync[1];
    assign to_hit = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge OSCCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (clk_fall) begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (data_s == START_VAL) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {data_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= data_s;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        if (data_s != STOP_VAL) begin
                            frame_err <= 1'b1;
                        end else if (!parity_ok(shift_reg, par_bit)) begin
                            parity_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            // A consume in this same cycle frees the register for the new byte.
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (to_hit) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                shift_reg <= '0;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else if (state != ST_IDLE) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of whole frames plus hand-written
// overrun, timeout, glitch and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ps2_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    // Pulse / handshake tallies sampled on the falling edge.
    int         n_perr  = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    int         n_vcyc  = 0;
    int         n_acc   = 0;
    logic [7:0] last_byte = 8'h00;

    ps2_rx #(
        .CLK_HZ     (1000000),
        .FILTER_LEN (8),
        .TIMEOUT_US (200)
    ) dut (
        .OSCCLK     (clk),
        .RESET_n    (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #500 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            n_perr += int'(parity_err);
            n_ferr += int'(frame_err);
            n_ovr  += int'(overrun);
            n_vcyc += int'(rx_valid);
            if (rx_valid && rx_ready) begin
                n_acc++;
                last_byte = rx_data;
            end
        end
    end

    initial begin
        #60_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit at 12.5 kHz with a 1 MHz system clock: 80 cycles per bit.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(20);
        ps2_clk = 1'b0;
        cyc(40);
        ps2_clk = 1'b1;
        cyc(20);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(20);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        logic       stop;
        int         exp_acc;
        int         exp_perr;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];

    int a0, p0, f0, o0, v0;

    task automatic snap();
        a0 = n_acc; p0 = n_perr; f0 = n_ferr; o0 = n_ovr; v0 = n_vcyc;
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
        vecs[2] = '{8'h32, 1'b0, 1'b1, 1, 0, 0, 8'h32};
        vecs[3] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1, 8'h32};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1, 0, 0, 8'h5A};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
        vecs[7] = '{8'hA5, 1'b1, 1'b1, 0, 1, 0, 8'hFF};

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rx_ready = 1'b1;
        cyc(3);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_err_pulses", 32'({parity_err, frame_err, overrun}), 32'h0);
        rst_n = 1'b1;
        cyc(10);

        // Table of complete frames, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            snap();
            send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop);
            cyc(20);
            check($sformatf("vec%0d_accepts", i), 32'(n_acc - a0), 32'(vecs[i].exp_acc));
            check($sformatf("vec%0d_valid_cycles", i), 32'(n_vcyc - v0), 32'(vecs[i].exp_acc));
            check($sformatf("vec%0d_parity_err", i), 32'(n_perr - p0), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_frame_err", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_byte", i), 32'(last_byte), 32'(vecs[i].exp_byte));
        end

        // Overrun: holding register full while a second good frame lands.
        snap();
        rx_ready = 1'b0;
        send_frame(8'hF0, 1'b0, 1'b1);
        cyc(20);
        check("ovr_first_valid", 32'(rx_valid), 32'h1);
        send_frame(8'h1C, 1'b0, 1'b1);
        cyc(20);
        check("ovr_pulses", 32'(n_ovr - o0), 32'h1);
        check("ovr_held_data", 32'(rx_data), 32'hF0);
        check("ovr_still_valid", 32'(rx_valid), 32'h1);
        check("ovr_no_err", 32'((n_perr - p0) + (n_ferr - f0)), 32'h0);
        rx_ready = 1'b1;
        cyc(3);
        check("ovr_consumed", 32'(n_acc - a0), 32'h1);
        check("ovr_consumed_byte", 32'(last_byte), 32'hF0);
        check("ovr_valid_cleared", 32'(rx_valid), 32'h0);

        // Timeout: clock stalls 250 us after the 4th data bit.
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        cyc(250);
        check("timeout_frame_err", 32'(n_ferr - f0), 32'h1);
        check("timeout_no_accept", 32'(n_acc - a0), 32'h0);
        snap();
        send_frame(8'h5A, 1'b0, 1'b1);
        cyc(20);
        check("after_timeout_accept", 32'(n_acc - a0), 32'h1);
        check("after_timeout_byte", 32'(last_byte), 32'h5A);
        check("after_timeout_no_err", 32'(n_ferr - f0), 32'h0);

        // Glitches: one while idle, one between data bits.
        snap();
        glitch();
        cyc(30);
        check("idle_glitch_quiet", 32'((n_acc - a0) + (n_perr - p0) + (n_ferr - f0)), 32'h0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        glitch();
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);   // parity for 0x33 (four ones)
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        cyc(20);
        check("data_glitch_accept", 32'(n_acc - a0), 32'h1);
        check("data_glitch_byte", 32'(last_byte), 32'h33);
        check("data_glitch_no_err", 32'((n_perr - p0) + (n_ferr - f0)), 32'h0);

        // Reset in the middle of a frame.
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        rst_n = 1'b0;
        cyc(2);
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_outputs", 32'({rx_valid, parity_err, frame_err, overrun}), 32'h0);
        rst_n = 1'b1;
        snap();
        cyc(300);
        check("post_reset_quiet", 32'((n_perr - p0) + (n_ferr - f0) + (n_ovr - o0) + (n_acc - a0)), 32'h0);
        send_frame(8'h1C, 1'b0, 1'b1);
        cyc(20);
        check("post_reset_accept", 32'(n_acc - a0), 32'h1);
        check("post_reset_byte", 32'(last_byte), 32'h1C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
